// File: rtl/ff_response_checker.sv
// ff_response_checker: checks a flip-flop under test against an ideal
// single-cycle model, counting mismatches and capturing the first failing index.
module ff_response_checker #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic [WIDTH-1:0] stim_d,
  input  logic             stim_rst,
  input  logic [WIDTH-1:0] dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] check_idx;
  logic [CNT_W-1:0] err_next;
  logic             mismatch;
  logic             last_check;

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic, status outputs and the saturating error increment.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mismatch   = (state == CHECK) && (dut_q != expected);
    last_check = (check_idx == (num_lat - CNT_W'(1)));
    err_next   = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + CNT_W'(1);
    case (state)
      IDLE: begin
        if (start) state_next = PRIME;
      end
      PRIME: begin
        busy = 1'b1;
        if (num_lat == '0) state_next = DONE;
        else               state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (last_check) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ideal flip-flop model: one cycle of latency, synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset)         expected <= '0;
    else if (stim_rst) expected <= '0;
    else               expected <= stim_d;
  end

  // Run bookkeeping. pass is resolved on entry to DONE from err_next so it
  // already includes the final comparison while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_lat         <= '0;
      check_idx       <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_lat         <= num_checks;
            check_idx       <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
          end
        end
        PRIME: begin
          check_idx <= '0;
          if (num_lat == '0) pass <= (err_count == '0);
        end
        CHECK: begin
          err_count <= err_next;
          check_idx <= check_idx + CNT_W'(1);
          if (mismatch && !first_err_valid) begin
            first_err_idx   <= check_idx;
            first_err_valid <= 1'b1;
          end
          if (last_check) pass <= (err_next == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_response_checker.sv
// Scoreboard bench: runs push expected results, monitors pop them on done.
module tb_ff_response_checker;

  localparam int W = 4;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] fei;
    logic        fev;
    int          busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start4 = 1'b0;
  logic [15:0]   num_checks = '0;
  logic [3:0]    num4 = '0;
  logic [W-1:0]  stim_d = '0;
  logic          stim_rst = 1'b0;
  logic          force_zero = 1'b0;
  logic [W-1:0]  q_model;
  logic [W-1:0]  dut_q;
  logic          q4;
  logic [0:0]    stim_d4;
  logic [0:0]    dut_q4;

  logic          busy, done, pass, first_err_valid;
  logic [15:0]   err_count, first_err_idx;
  logic          busy4, done4, pass4, fev4;
  logic [3:0]    err4, fei4;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  exp_t sb4[$];

  // Reference flip-flops: honor stim_rst; dut4 sees an inverted Q.
  always_ff @(posedge clk) begin
    q_model <= stim_rst ? '0 : stim_d;
    q4      <= stim_rst ? 1'b0 : stim_d[0];
  end
  assign dut_q   = force_zero ? '0 : q_model;
  assign stim_d4 = stim_d[0:0];
  assign dut_q4  = ~q4;

  ff_response_checker #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .stim_d(stim_d), .stim_rst(stim_rst), .dut_q(dut_q),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
  );

  ff_response_checker #(.WIDTH(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .num_checks(num4),
    .stim_d(stim_d4), .stim_rst(stim_rst), .dut_q(dut_q4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_idx(fei4), .first_err_valid(fev4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Main-instance monitor.
  int   busy_cnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (reset) busy_cnt = 0;
    else if (done) begin
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        me = sb.pop_front();
        check("pass", {31'd0, pass}, {31'd0, me.pass});
        check("err_count", {16'd0, err_count}, {16'd0, me.err});
        check("first_err_idx", {16'd0, first_err_idx}, {16'd0, me.fei});
        check("first_err_valid", {31'd0, first_err_valid}, {31'd0, me.fev});
        check("busy_cycles", busy_cnt, me.busy);
      end
      busy_cnt = 0;
    end else if (busy) busy_cnt++;
  end

  // Narrow-counter instance monitor.
  int   busy4_cnt = 0;
  exp_t me4;
  always @(negedge clk) begin
    if (reset) busy4_cnt = 0;
    else if (done4) begin
      if (sb4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        me4 = sb4.pop_front();
        check("pass4", {31'd0, pass4}, {31'd0, me4.pass});
        check("err4", {28'd0, err4}, {16'd0, me4.err});
        check("fei4", {28'd0, fei4}, {16'd0, me4.fei});
        check("fev4", {31'd0, fev4}, {31'd0, me4.fev});
        check("busy4_cycles", busy4_cnt, me4.busy);
      end
      busy4_cnt = 0;
    end else if (busy4) busy4_cnt++;
  end

  task automatic drive(input int k, input logic [W-1:0] d_a, input logic [W-1:0] d_b,
                       input logic [31:0] rst_mask);
    stim_d   = (k % 2 == 1) ? d_b : d_a;
    stim_rst = rst_mask[k];
  endtask

  // One run: start, PRIME, n checks, DONE, then confirm results hold in IDLE.
  task automatic run(input int n, input logic [W-1:0] d_a, input logic [W-1:0] d_b,
                     input logic [31:0] rst_mask, input logic [31:0] fz_mask,
                     input bit start_again, input logic e_pass, input int e_err,
                     input int e_fei, input logic e_fev);
    exp_t e;
    e.pass = e_pass; e.err = 16'(e_err); e.fei = 16'(e_fei); e.fev = e_fev; e.busy = n + 1;
    sb.push_back(e);
    start = 1'b1; num_checks = 16'(n);
    @(posedge clk); #1;
    start = start_again;
    drive(0, d_a, d_b, rst_mask);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive(k + 1, d_a, d_b, rst_mask);
      force_zero = fz_mask[k];
      @(posedge clk); #1;
    end
    force_zero = 1'b0;
    stim_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_busy", {31'd0, busy}, 32'd0);
    check("hold_pass", {31'd0, pass}, {31'd0, e_pass});
    check("hold_err", {16'd0, err_count}, 32'(e_err));
    check("hold_fev", {31'd0, first_err_valid}, {31'd0, e_fev});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    check("rst_fei", {16'd0, first_err_idx}, 32'd0);
    check("rst_fev", {31'd0, first_err_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //  n  d_a    d_b    rst_mask  fz_mask   again pass err fei fev
    run(8, 4'h5, 4'hA, 32'h0,    32'h0,    0,    1,   0,  0,  0);
    run(8, 4'h5, 4'hA, 32'h0,    32'h8,    0,    0,   1,  3,  1);
    run(0, 4'h5, 4'hA, 32'h0,    32'h0,    1,    1,   0,  0,  0);
    run(8, 4'hF, 4'hF, 32'h1C,   32'h0,    0,    1,   0,  0,  0);
    run(8, 4'h5, 4'hA, 32'h0,    32'h2A,   0,    0,   3,  1,  1);
    run(8, 4'h5, 4'hA, 32'h0,    32'h80,   0,    0,   1,  7,  1);
    run(1, 4'h5, 4'hA, 32'h0,    32'h1,    0,    0,   1,  0,  1);
    run(6, 4'hF, 4'hF, 32'h1C,   32'h28,   0,    0,   1,  5,  1);
    run(3, 4'h3, 4'hC, 32'h0,    32'h0,    1,    1,   0,  0,  0);

    // Abort at check index 5 after a mismatch at index 2.
    start = 1'b1; num_checks = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    drive(0, 4'h5, 4'hA, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      drive(k + 1, 4'h5, 4'hA, 32'h0);
      force_zero = (k == 2);
      @(posedge clk); #1;
    end
    force_zero = 1'b0;
    check("pre_abort_err", {16'd0, err_count}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err", {16'd0, err_count}, 32'd0);
    check("abort_fei", {16'd0, first_err_idx}, 32'd0);
    check("abort_fev", {31'd0, first_err_valid}, 32'd0);
    check("abort_pass", {31'd0, pass}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    run(8, 4'h5, 4'hA, 32'h0, 32'h0, 0, 1, 0, 0, 0);

    // Narrow counters, Q stuck at inverse for all 15 checks.
    begin
      exp_t e;
      e.pass = 1'b0; e.err = 16'd15; e.fei = 16'd0; e.fev = 1'b1; e.busy = 16;
      sb4.push_back(e);
    end
    start4 = 1'b1; num4 = 4'd15;
    @(posedge clk); #1;
    start4 = 1'b0;
    drive(0, 4'h0, 4'h1, 32'h0);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      drive(k + 1, 4'h0, 4'h1, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("sat_err_hold", {28'd0, err4}, 32'd15);

    for (int t = 0; t < 20 && (sb.size() != 0 || sb4.size() != 0); t++) @(posedge clk);
    check("scoreboard_drained", sb.size() + sb4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
